// File: rtl/row_scan_pkg.sv
// row_scan_pkg: shared state encoding, sizes and next-row selection for the row scan sequencer
package row_scan_pkg;
  localparam int ROW_IDX_W = 3;
  localparam int MAX_ROWS = 8;
  typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;
  // Lowest enabled row above idx, else wrap to the lowest enabled row
  function automatic logic [ROW_IDX_W-1:0] next_row(input logic [ROW_IDX_W-1:0] idx,
                                                    input logic [MAX_ROWS-1:0] mask,
                                                    input int num_rows);
    logic [ROW_IDX_W-1:0] lo, hi;
    logic hf;
    lo = '0;
    hi = '0;
    hf = 1'b0;
    for (int r = MAX_ROWS - 1; r >= 0; r--) begin
      if (mask[r] && r < num_rows) begin
        lo = ROW_IDX_W'(r);
        if (r > int'(idx)) begin
          hi = ROW_IDX_W'(r);
          hf = 1'b1;
        end
      end
    end
    return hf ? hi : lo;
  endfunction
endpackage

// File: rtl/row_scan_if.sv
// row_scan_if: scan control and decoder-side outputs; row_mask exists only with ROW_MASK_EN
interface row_scan_if;
  import row_scan_pkg::*;
  logic en;
`ifdef ROW_MASK_EN
  logic [MAX_ROWS-1:0] row_mask;
`endif
  logic [ROW_IDX_W-1:0] row_idx;
  logic row_valid;
  logic frame_start;
  logic row_done;
  modport master(input en,
`ifdef ROW_MASK_EN
    input row_mask,
`endif
    output row_idx, row_valid, frame_start, row_done);
  modport slave(output en,
`ifdef ROW_MASK_EN
    output row_mask,
`endif
    input row_idx, row_valid, frame_start, row_done);
endinterface

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter that stops at zero
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/row_scan_sequencer.sv
// row_scan_sequencer: blank/dwell row scanner for the 3-to-8 decoder; ROW_MASK_EN adds row_mask skipping
module row_scan_sequencer
  import row_scan_pkg::*;
#(
  parameter int NUM_ROWS = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  row_scan_if.master io
);
  localparam int TW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1);
  localparam logic [MAX_ROWS-1:0] LIM = MAX_ROWS'((9'd1 << NUM_ROWS) - 9'd1);
  state_t state, nxt;
  logic [TW-1:0] cnt, load_val;
  logic zero, load, go, wrap;
  logic [MAX_ROWS-1:0] mask;
  logic [ROW_IDX_W-1:0] first, step;
`ifdef ROW_MASK_EN
  assign mask = io.row_mask;
`else
  assign mask = '1;
`endif
  assign first = next_row(ROW_IDX_W'(MAX_ROWS - 1), mask, NUM_ROWS);
  assign step = next_row(io.row_idx, mask, NUM_ROWS);
  assign wrap = state == IDLE || step <= io.row_idx;
  always_comb begin
    go = io.en && |(mask & LIM);
    nxt = state == IDLE  ? (go ? BLANK : IDLE) :
          state == BLANK ? (zero ? DWELL : BLANK) :
          zero ? (go ? BLANK : IDLE) : DWELL;
    load = nxt != state;
    load_val = nxt == BLANK ? TW'(BLANK_CYCLES - 1) : nxt == DWELL ? TW'(DWELL_CYCLES - 1) : '0;
  end
  scan_timer #(.W(TW)) u_tmr (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .cnt(cnt), .zero(zero)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      io.row_idx <= '0;
      io.row_valid <= 1'b0;
      io.frame_start <= 1'b0;
      io.row_done <= 1'b0;
    end else begin
      state <= nxt;
      io.row_valid <= nxt == DWELL;
      io.frame_start <= load && nxt == BLANK && wrap;
      io.row_done <= nxt == DWELL && (load ? DWELL_CYCLES == 1 : cnt == TW'(1));
      if (load && nxt == BLANK) io.row_idx <= state == IDLE ? first : step;
    end
  end
endmodule

// File: tb/tb_row_scan_sequencer.sv
// tb_row_scan_sequencer: three configurations checked every cycle against a timeline model
module tb_row_scan_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;
  int e = 0;
  int nr[3] = '{8, 3, 2};
  int bl[3] = '{2, 2, 1};
  int dw[3] = '{4, 4, 1};
  int act[3], st[3], xidx[3], xval[3], xfs[3], xdone[3];

  always #5 clk = ~clk;

  row_scan_if ia();
  row_scan_if ib();
  row_scan_if ic();
  assign ia.en = en;
  assign ib.en = en;
  assign ic.en = en;
`ifdef ROW_MASK_EN
  assign ia.row_mask = 8'hff;
  assign ib.row_mask = 8'hff;
  assign ic.row_mask = 8'hff;
`endif

  row_scan_sequencer #(.NUM_ROWS(8), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) da (.clk(clk), .rst_n(rst_n), .io(ia));
  row_scan_sequencer #(.NUM_ROWS(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) db (.clk(clk), .rst_n(rst_n), .io(ib));
  row_scan_sequencer #(.NUM_ROWS(2), .DWELL_CYCLES(1), .BLANK_CYCLES(1)) dc (.clk(clk), .rst_n(rst_n), .io(ic));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 0; st[i] = 0; xidx[i] = 0; xval[i] = 0; xfs[i] = 0; xdone[i] = 0;
    end
  endtask

  // Row schedule from the start edge: period = blank + dwell, stop only at a row's end
  task automatic model(input int i);
    int p, o;
    p = bl[i] + dw[i];
    if (act[i] != 0) begin
      o = (e - 1 - st[i]) % p;
      if (o == p - 1 && !en) act[i] = 0;
    end else if (en) begin
      act[i] = 1;
      st[i] = e;
    end
    if (act[i] != 0) begin
      o = (e - st[i]) % p;
      xidx[i] = ((e - st[i]) / p) % nr[i];
      xval[i] = int'(o >= bl[i]);
      xdone[i] = int'(o == p - 1);
      xfs[i] = int'(o == 0 && xidx[i] == 0);
    end else begin
      xval[i] = 0; xdone[i] = 0; xfs[i] = 0;
    end
  endtask

  task automatic cmp(input int i, input logic [2:0] idx, input logic v, input logic f, input logic d);
    chk($sformatf("d%0d_row_idx", i), int'(idx), xidx[i]);
    chk($sformatf("d%0d_row_valid", i), int'(v), xval[i]);
    chk($sformatf("d%0d_frame_start", i), int'(f), xfs[i]);
    chk($sformatf("d%0d_row_done", i), int'(d), xdone[i]);
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    for (int i = 0; i < 3; i++) model(i);
    #1;
    cmp(0, ia.row_idx, ia.row_valid, ia.frame_start, ia.row_done);
    cmp(1, ib.row_idx, ib.row_valid, ib.frame_start, ib.row_done);
    cmp(2, ic.row_idx, ic.row_valid, ic.frame_start, ic.row_done);
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    cmp(0, ia.row_idx, ia.row_valid, ia.frame_start, ia.row_done);
    cmp(1, ib.row_idx, ib.row_valid, ib.frame_start, ib.row_done);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    en = 1'b1;
    for (int k = 0; k < 60; k++) step();
    for (int k = 0; k < 500; k++) begin
      en = $urandom_range(0, 7) != 0;
      step();
    end
    en = 1'b0;
    for (int k = 0; k < 12; k++) step();
    en = 1'b1;
    for (int k = 0; k < 20; k++) step();
    n = 0;
    while (xval[0] == 0 && n < 20) begin
      step();
      n++;
    end
    chk("pre_reset_in_dwell", int'(ia.row_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp(0, ia.row_idx, ia.row_valid, ia.frame_start, ia.row_done);
    cmp(1, ib.row_idx, ib.row_valid, ib.frame_start, ib.row_done);
    cmp(2, ic.row_idx, ic.row_valid, ic.frame_start, ic.row_done);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    for (int k = 0; k < 200; k++) begin
      en = $urandom_range(0, 9) != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
